// File: rtl/ifu_fetch_buffer_if.sv
// ifu_fetch_buffer_if
//   Groups the fetch unit's bus signals: the instruction-memory request and
//   response channels, the redirect input and the decoder-facing output.
//   master : fetch unit view. It drives the memory request and the decoder
//            output, and receives the memory response, the redirect and
//            out_ready.
//   slave  : environment view (memory, redirect source, decoder).
// Parameters
//   XLEN    PC/address width
//   INST_W  instruction width
interface ifu_fetch_buffer_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned INST_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_inst;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [XLEN-1:0]   out_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_inst,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_inst,
           redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifu_fetch_buffer.sv
// ifu_fetch_buffer
//   Fetch stage in front of the decoder. It owns the fetch PC and issues
//   in-order requests to instruction memory. Returned {pc, inst} pairs are
//   buffered in a DEPTH-entry FIFO and presented to the decoder. A redirect
//   restarts fetch at a new PC. Wrong-path instructions are discarded,
//   whether buffered or still in flight.
// Ports
//   clk  clock; all state updates on posedge
//   rst  asynchronous active-low reset (0 = reset)
//   bus  ifu_fetch_buffer_if.master, which carries:
//        - the imem request (valid/ready/addr)
//        - the imem response (valid/inst)
//        - the redirect (valid/pc)
//        - the decoder output (valid/ready/inst/pc)
// Configuration
//   IFU_BYPASS_EN  When defined, a response that arrives while the FIFO is
//                  empty and nothing is being dropped drives out_* in the
//                  same cycle. If it is consumed in that cycle, it is not
//                  written to the FIFO. When undefined, out_* come only from
//                  registers.
module ifu_fetch_buffer #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INST_W   = 32,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst,
  ifu_fetch_buffer_if.master bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetchState_e;

  fetchState_e       state, stateNext;
  logic [XLEN-1:0]   fetchPc;
  logic [CW-1:0]     inflight, drop, dropNext, count, outstanding;
  logic [AW-1:0]     qRdPtr, qWrPtr, rdPtr, wrPtr;
  logic [CW:0]       occupancy;

  // pcQueue remembers the address of every accepted request until its
  // response returns. pcMem/instMem hold the decoder-facing FIFO.
  logic [XLEN-1:0]   pcQueue [DEPTH];
  logic [XLEN-1:0]   pcMem   [DEPTH];
  logic [INST_W-1:0] instMem [DEPTH];

  logic running, redirEff, reqValid, reqFire, respFire, respKeep;
  logic bypassValid, fifoPush, fifoPop, outValid;

  always_comb begin
    running   = (state != BOOT);
    // A redirect that arrives during the single boot cycle has no effect.
    redirEff  = bus.redirect_valid && running;
    // Credit rule: in-flight requests plus buffered entries never exceed
    // DEPTH, so every response has a FIFO slot waiting for it.
    occupancy = {1'b0, inflight} + {1'b0, count};
    reqValid  = running && (occupancy < (CW+1)'(DEPTH)) && !bus.redirect_valid;
    reqFire   = reqValid && bus.imem_req_ready;
    respFire  = bus.imem_resp_valid && (inflight != '0);
    respKeep  = respFire && (drop == '0) && !redirEff;
`ifdef IFU_BYPASS_EN
    bypassValid = respKeep && (count == '0);
`else
    bypassValid = 1'b0;
`endif
    outValid    = (count != '0) || bypassValid;
    fifoPop     = (count != '0) && bus.out_ready;
    fifoPush    = respKeep && !(bypassValid && bus.out_ready);
    // Requests still owed a response at the end of this cycle.
    outstanding = inflight + CW'(reqFire) - CW'(respFire);
  end

  // Next-state logic. After a redirect, every response still owed belongs
  // to the wrong path. Those responses are counted into drop, and DRAIN
  // lasts until that count reaches zero.
  always_comb begin
    stateNext = state;
    dropNext  = drop;
    unique case (state)
      BOOT: stateNext = RUN;
      RUN, DRAIN: begin
        if (redirEff)
          dropNext = outstanding;
        else if (respFire && (drop != '0))
          dropNext = drop - CW'(1);
        stateNext = (dropNext != '0) ? DRAIN : RUN;
      end
      default: stateNext = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      fetchPc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      qRdPtr   <= '0;
      qWrPtr   <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
    end else begin
      state    <= stateNext;
      drop     <= dropNext;
      inflight <= outstanding;
      if (redirEff)
        fetchPc <= bus.redirect_pc;
      else if (reqFire)
        fetchPc <= fetchPc + XLEN'(4);
      // The in-flight queue is never flushed: dropped responses still pop
      // it, which keeps it aligned with the memory's in-order returns.
      if (reqFire)
        qWrPtr <= qWrPtr + AW'(1);
      if (respFire)
        qRdPtr <= qRdPtr + AW'(1);
      if (redirEff) begin
        count <= '0;
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        count <= count + CW'(fifoPush) - CW'(fifoPop);
        if (fifoPush)
          wrPtr <= wrPtr + AW'(1);
        if (fifoPop)
          rdPtr <= rdPtr + AW'(1);
      end
    end
  end

  // Storage is not reset. Reads are qualified by count or bypassValid, and
  // both of these are forced to zero while rst is low.
  always_ff @(posedge clk) begin
    if (reqFire)
      pcQueue[qWrPtr] <= fetchPc;
    if (fifoPush) begin
      pcMem[wrPtr]   <= pcQueue[qRdPtr];
      instMem[wrPtr] <= bus.imem_resp_inst;
    end
  end

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = fetchPc;
  assign bus.out_valid      = outValid;
  assign bus.out_pc   = (count != '0) ? pcMem[rdPtr]
                      : (bypassValid ? pcQueue[qRdPtr] : '0);
  assign bus.out_inst = (count != '0) ? instMem[rdPtr]
                      : (bypassValid ? bus.imem_resp_inst : '0);

  respNeedsOutstanding: assert property (
    @(posedge clk) disable iff (!rst) bus.imem_resp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// tb_ifu_fetch_buffer
//   Scoreboard bench for ifu_fetch_buffer. The in-order memory model pushes
//   the expected {pc, inst} onto expQ whenever a request is accepted. expQ
//   is cleared on redirect, and each decoder handshake pops it and compares.
//   Works with or without IFU_BYPASS_EN (the latency expectation follows).
module tb_ifu_fetch_buffer;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 2;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
`ifdef IFU_BYPASS_EN
  localparam int BYP_EXTRA = 0;
`else
  localparam int BYP_EXTRA = 1;
`endif

  typedef struct { logic [63:0] addr; int due; } memEnt_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } expEnt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_buffer_if #(.XLEN(XLEN), .INST_W(INST_W)) bus ();

  ifu_fetch_buffer #(
    .XLEN(XLEN), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  memEnt_t     memQ[$];
  expEnt_t     expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          latMin = 1, latMax = 1;
  int          reqCount = 0, outCount = 0;
  int          firstReqCyc = -1, firstOutCyc = -1;
  bit          memReady = 1'b0;
  bit          holdCheck = 1'b0;
  logic [63:0] lastOutPc = '0;

  function automatic logic [31:0] instOf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_inst  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.out_ready       = 1'b0;
  endtask

  // One clock cycle, entered and left at the negedge.
  // If tryRedir is set, a redirect together with out_ready is applied only
  // in a cycle where a response and an output handshake coincide.
  task automatic doCycle(input bit redir, input logic [63:0] rpc, input bit ordy,
                         input bit tryRedir, output bit didRedir);
    bit      rv;
    expEnt_t e;
    memEnt_t m;
    rv = (memQ.size() > 0) && (memQ[0].due <= cyc);
    bus.imem_resp_valid = rv;
    bus.imem_resp_inst  = rv ? instOf(memQ[0].addr) : '0;
    bus.imem_req_ready  = memReady;
    bus.redirect_valid  = redir;
    bus.redirect_pc     = rpc;
    bus.out_ready       = ordy;
    didRedir = redir;
    #1;
    if (tryRedir) begin
      bus.redirect_valid = 1'b1;
      bus.out_ready      = 1'b1;
      #1;
      if (bus.out_valid && rv) begin
        didRedir = 1'b1;
      end else begin
        bus.redirect_valid = redir;
        bus.out_ready      = ordy;
        #1;
      end
    end
    if (holdCheck && bus.out_valid && expQ.size() > 0)
      checkVal("hold_pc", bus.out_pc, expQ[0].pc);
    if (bus.out_valid && firstOutCyc < 0)
      firstOutCyc = cyc;
    if (bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checkVal("out_extra", {63'b0, bus.out_valid}, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkVal("out_pc", bus.out_pc, e.pc);
        checkVal("out_inst", {32'b0, bus.out_inst}, {32'b0, e.inst});
      end
      $display("OUT cyc=%0d pc=%h inst=%h", cyc, bus.out_pc, bus.out_inst);
      lastOutPc = bus.out_pc;
      outCount++;
    end
    if (rv)
      void'(memQ.pop_front());
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      m.addr = bus.imem_req_addr;
      m.due  = cyc + int'($urandom_range(latMax, latMin));
      memQ.push_back(m);
      e.pc   = bus.imem_req_addr;
      e.inst = instOf(bus.imem_req_addr);
      expQ.push_back(e);
      reqCount++;
      if (firstReqCyc < 0)
        firstReqCyc = cyc;
    end
    if (didRedir) begin
      $display("REDIRECT cyc=%0d pc=%h", cyc, bus.redirect_pc);
      expQ.delete();
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input string tag);
    bit d;
    memReady = 1'b0;
    for (int i = 0; i < 40 && (memQ.size() != 0 || expQ.size() != 0); i++)
      doCycle(1'b0, '0, 1'b1, 1'b0, d);
    checkVal(tag, 64'(expQ.size()), 64'd0);
    memReady = 1'b1;
  endtask

  // Reset release: one BOOT cycle without a request, then RESET_PC.
  task automatic releaseReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal({tag, "_boot_req_valid"}, {63'b0, bus.imem_req_valid}, 64'd0);
    @(negedge clk);
    checkVal({tag, "_first_req_valid"}, {63'b0, bus.imem_req_valid}, 64'd1);
    checkVal({tag, "_first_addr"}, bus.imem_req_addr, RESET_PC);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit          d;
    int          base;
    logic [63:0] rp;
    clearInputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkVal("rst_req_valid", {63'b0, bus.imem_req_valid}, 64'd0);
    checkVal("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    checkVal("rst_out_pc", bus.out_pc, 64'd0);
    checkVal("rst_out_inst", {32'b0, bus.out_inst}, 64'd0);
    releaseReset("t1");

    // 1: streaming with 1-cycle memory and an always-ready decoder
    memReady = 1'b1; latMin = 1; latMax = 1;
    firstReqCyc = -1; firstOutCyc = -1;
    repeat (20) doCycle(1'b0, '0, 1'b1, 1'b0, d);
    checkVal("latency", 64'(firstOutCyc - firstReqCyc), 64'(1 + BYP_EXTRA));
    drain("drain1");

    // 2: decoder stalls for 10 cycles
    reqCount = 0; holdCheck = 1'b1;
    repeat (10) doCycle(1'b0, '0, 1'b0, 1'b0, d);
    holdCheck = 1'b0;
    checkVal("stall_reqs", 64'(reqCount), 64'(DEPTH));
    checkVal("full_req_valid", {63'b0, bus.imem_req_valid}, 64'd0);
    checkVal("full_out_valid", {63'b0, bus.out_valid}, 64'd1);
    repeat (12) doCycle(1'b0, '0, 1'b1, 1'b0, d);
    drain("drain2");

    // 3: redirect with two requests outstanding
    latMin = 5; latMax = 5;
    for (int i = 0; i < 10 && memQ.size() < 2; i++)
      doCycle(1'b0, '0, 1'b1, 1'b0, d);
    checkVal("two_outstanding", 64'(memQ.size()), 64'd2);
    doCycle(1'b1, 64'h8000_1000, 1'b1, 1'b0, d);
    checkVal("redir_next_addr", bus.imem_req_addr, 64'h8000_1000);
    latMin = 1; latMax = 1;
    base = outCount;
    for (int i = 0; i < 30 && outCount == base; i++)
      doCycle(1'b0, '0, 1'b1, 1'b0, d);
    checkVal("redir_first_pc", lastOutPc, 64'h8000_1000);
    drain("drain3");

    // 4: redirect coinciding with a response and an output handshake
    latMin = 2; latMax = 2;
    base = outCount; d = 1'b0;
    for (int i = 0; i < 30 && !d; i++)
      doCycle(1'b0, 64'h8000_2000, 1'b0, 1'b1, d);
    checkVal("coincide_hit", {63'b0, d}, 64'd1);
    checkVal("coincide_consumed", 64'(outCount - base), 64'd1);
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b0;
    #1;
    checkVal("coincide_out_valid", {63'b0, bus.out_valid}, 64'd0);
    latMin = 1; latMax = 1;
    repeat (6) doCycle(1'b0, '0, 1'b1, 1'b0, d);
    drain("drain4");

    // 5: address wrap at the top of the address space
    doCycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, d);
    bus.redirect_valid  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    #1;
    checkVal("wrap_req_valid", {63'b0, bus.imem_req_valid}, 64'd1);
    checkVal("wrap_addr_hi", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    doCycle(1'b0, '0, 1'b1, 1'b0, d);
    checkVal("wrap_addr_zero", bus.imem_req_addr, 64'd0);
    repeat (6) doCycle(1'b0, '0, 1'b1, 1'b0, d);
    drain("drain5");

    // 6: asynchronous reset with the FIFO full
    repeat (6) doCycle(1'b0, '0, 1'b0, 1'b0, d);
    checkVal("pre_rst_out_valid", {63'b0, bus.out_valid}, 64'd1);
    #2;
    rst = 1'b0;
    clearInputs();
    #1;
    checkVal("async_out_valid", {63'b0, bus.out_valid}, 64'd0);
    checkVal("async_req_valid", {63'b0, bus.imem_req_valid}, 64'd0);
    checkVal("async_out_pc", bus.out_pc, 64'd0);
    memQ.delete();
    expQ.delete();
    releaseReset("t6");
    firstReqCyc = -1; firstOutCyc = -1;
    repeat (12) doCycle(1'b0, '0, 1'b1, 1'b0, d);
    checkVal("latency_after_rst", 64'(firstOutCyc - firstReqCyc), 64'(1 + BYP_EXTRA));
    drain("drain6");

    // Random mix: memory stalls, variable latency, decoder stalls, redirects
    latMin = 1; latMax = 3;
    for (int i = 0; i < 300; i++) begin
      memReady = ($urandom_range(3, 0) != 0);
      rp = {32'h0, $urandom() & 32'hFFFF_FFFC};
      doCycle(($urandom_range(24, 0) == 0), rp, ($urandom_range(2, 0) != 0), 1'b0, d);
    end
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
